// File: rtl/imem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : imem_pkg                                               |
// | Shared FSM state type and fault-check constants for the          |
// | instruction-memory responder.                                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package imem_pkg;

  // Byte-offset bits below the word index; nonzero means misaligned fetch.
  localparam int c_BYTE_OFS_W = 2;

  // Wait counter holds any WAIT value in 0..7.
  localparam int c_WAIT_MAX   = 7;
  localparam int c_WCNT_W     = $clog2(c_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : imem_array                                             |
// | Word-addressed instruction storage: synchronous write port for   |
// | program loading, combinational read port for fetch capture.      |
// | Contents are deliberately not reset.                             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module imem_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];

  // Program-load write; no reset so a loaded image survives core resets.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Combinational read returns the pre-write content in a write cycle.
  always_comb begin
    rdata = r_mem[raddr];
  end

endmodule : imem_array
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : imem_responder                                         |
// | Single-outstanding instruction fetch responder with a fixed      |
// | number of wait cycles, alignment/range fault detection and a     |
// | program-load write port into the backing array.                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module imem_responder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_data,
  output logic                     rsp_err,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [XLEN-1:0]          prog_data
);

  import imem_pkg::*;

  localparam int c_AW = $clog2(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic [c_WCNT_W-1:0] r_wcnt;
  logic [XLEN-1:0]     r_data;
  logic                r_err;

  logic                w_accept;
  logic                w_misalign;
  logic                w_oor;
  logic                w_fault;
  logic [c_AW-1:0]     w_ridx;
  logic [XLEN-1:0]     w_word;

  assign w_ridx     = req_addr[c_BYTE_OFS_W +: c_AW];
  assign w_misalign = |req_addr[c_BYTE_OFS_W-1:0];
  // Range test uses the full word address, so high address bits fault.
  assign w_oor      = (req_addr >> c_BYTE_OFS_W) >= XLEN'(DEPTH);
  assign w_fault    = w_misalign | w_oor;
  assign w_accept   = req_valid & (r_state == ST_IDLE);

  imem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (w_ridx),
    .rdata (w_word)
  );

  // State register; reset aborts any outstanding request immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: WAIT exits when the counter is on its last wait cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next = (WAIT == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_wcnt[c_WCNT_W-1:1] == '0) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state.
  always_comb begin
    req_ready = (r_state == ST_IDLE);
    rsp_valid = (r_state == ST_RESP);
  end

  // Wait counter: loads WAIT on entry to WAIT, counts down, never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt <= '0;
    end else if ((r_state == ST_IDLE) && (w_next == ST_WAIT)) begin
      r_wcnt <= c_WCNT_W'(WAIT);
    end else if ((r_state == ST_WAIT) && (r_wcnt != '0)) begin
      r_wcnt <= r_wcnt - 1'b1;
    end
  end

  // Response register captured only at acceptance, so it stays stable in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_data <= w_fault ? '0 : w_word;
      r_err  <= w_fault;
    end
  end

  assign rsp_data = r_data;
  assign rsp_err  = r_err;

endmodule : imem_responder
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_imem_responder                                      |
// | Directed self-checking bench for imem_responder, exercising a    |
// | WAIT=2 and a WAIT=0 instance sharing clock, reset and prog bus.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_imem_responder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            reset;
  logic            prog_we;
  logic [AW-1:0]   prog_addr;
  logic [XLEN-1:0] prog_data;

  logic            w2_req_valid, w2_req_ready, w2_rsp_valid, w2_rsp_ready, w2_rsp_err;
  logic [XLEN-1:0] w2_req_addr, w2_rsp_data;
  logic            w0_req_valid, w0_req_ready, w0_rsp_valid, w0_rsp_ready, w0_rsp_err;
  logic [XLEN-1:0] w0_req_addr, w0_rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imem_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .WAIT(2)) u_dut_w2 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (w2_req_valid),
    .req_ready (w2_req_ready),
    .req_addr  (w2_req_addr),
    .rsp_valid (w2_rsp_valid),
    .rsp_ready (w2_rsp_ready),
    .rsp_data  (w2_rsp_data),
    .rsp_err   (w2_rsp_err),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  imem_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .WAIT(0)) u_dut_w0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (w0_req_valid),
    .req_ready (w0_req_ready),
    .req_addr  (w0_req_addr),
    .rsp_valid (w0_rsp_valid),
    .rsp_ready (w0_rsp_ready),
    .rsp_data  (w0_rsp_data),
    .rsp_err   (w0_rsp_err),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic load(input logic [AW-1:0] idx, input logic [XLEN-1:0] data);
    prog_we   = 1'b1;
    prog_addr = idx;
    prog_data = data;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  // Full fetch on the WAIT=2 instance: latency, payload, then handshake back to idle.
  task automatic w2_fetch(input string tag, input logic [XLEN-1:0] addr,
                          input logic [XLEN-1:0] exp_data, input logic exp_err);
    int lat;
    w2_req_valid = 1'b1;
    w2_req_addr  = addr;
    @(negedge clk);
    w2_req_valid = 1'b0;
    lat = 1;
    while (!w2_rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, 3);
    check({tag, ".data"}, w2_rsp_data, exp_data);
    check({tag, ".err"}, w2_rsp_err, exp_err);
    w2_rsp_ready = 1'b1;
    @(negedge clk);
    w2_rsp_ready = 1'b0;
    check({tag, ".req_ready"}, w2_req_ready, 1);
  endtask

  initial begin
    int seen;
    reset        = 1'b0;
    prog_we      = 1'b0;
    prog_addr    = '0;
    prog_data    = '0;
    w2_req_valid = 1'b0;
    w2_req_addr  = '0;
    w2_rsp_ready = 1'b0;
    w0_req_valid = 1'b0;
    w0_req_addr  = '0;
    w0_rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset.req_ready", w2_req_ready, 1);
    check("reset.rsp_valid", w2_rsp_valid, 0);
    check("reset.rsp_data", w2_rsp_data, 0);
    check("reset.rsp_err", w2_rsp_err, 0);
    check("reset.w0_rsp_valid", w0_rsp_valid, 0);

    // Program load
    reset = 1'b1;
    load(8'd0,   32'h0050_0093);
    load(8'd1,   32'h00A0_0113);
    load(8'd2,   32'h1111_1111);
    load(8'd3,   32'h2222_2222);
    load(8'd255, 32'hDEAD_BEEF);

    // Core reset pulse, then a request on the very first edge after release
    reset = 1'b0;
    @(negedge clk);
    reset        = 1'b1;
    w2_req_valid = 1'b1;
    w2_req_addr  = 32'h0;
    @(negedge clk);
    w2_req_valid = 1'b0;
    check("first.accepted", w2_req_ready, 0);
    check("first.wait1_valid", w2_rsp_valid, 0);
    @(negedge clk);
    check("first.wait2_valid", w2_rsp_valid, 0);
    @(negedge clk);
    check("first.rsp_valid", w2_rsp_valid, 1);
    check("first.rsp_data", w2_rsp_data, 32'h0050_0093);
    check("first.rsp_err", w2_rsp_err, 0);

    // Back-pressure: five cycles with rsp_ready low and a stray request pulse
    for (int i = 0; i < 5; i++) begin
      w2_req_valid = (i == 1);
      w2_req_addr  = 32'h4;
      check("hold.rsp_valid", w2_rsp_valid, 1);
      check("hold.rsp_data", w2_rsp_data, 32'h0050_0093);
      check("hold.req_ready", w2_req_ready, 0);
      @(negedge clk);
    end
    w2_req_valid = 1'b0;
    w2_rsp_ready = 1'b1;
    @(negedge clk);
    w2_rsp_ready = 1'b0;
    check("hold.release_ready", w2_req_ready, 1);
    check("hold.release_valid", w2_rsp_valid, 0);
    repeat (3) @(negedge clk);
    check("hold.pulse_ignored", w2_rsp_valid, 0);

    // Faults and range boundary
    w2_fetch("misalign6", 32'h6, 32'h0, 1'b1);
    w2_fetch("oor400", 32'h400, 32'h0, 1'b1);
    w2_fetch("last_word", 32'h3FC, 32'hDEAD_BEEF, 1'b0);
    w2_fetch("word1", 32'h4, 32'h00A0_0113, 1'b0);

    // Program write during WAIT does not disturb the captured response
    w2_req_valid = 1'b1;
    w2_req_addr  = 32'h8;
    @(negedge clk);
    w2_req_valid = 1'b0;
    check("wr_wait.in_wait", w2_rsp_valid, 0);
    prog_we   = 1'b1;
    prog_addr = 8'd2;
    prog_data = 32'hFFFF_FFFF;
    @(negedge clk);
    prog_we = 1'b0;
    @(negedge clk);
    check("wr_wait.rsp_valid", w2_rsp_valid, 1);
    check("wr_wait.old_word", w2_rsp_data, 32'h1111_1111);
    w2_rsp_ready = 1'b1;
    @(negedge clk);
    w2_rsp_ready = 1'b0;
    w2_fetch("after_write", 32'h8, 32'hFFFF_FFFF, 1'b0);

    // WAIT=0 instance: one-cycle response, rsp_ready high throughout
    w0_req_valid = 1'b1;
    w0_req_addr  = 32'h4;
    w0_rsp_ready = 1'b1;
    @(negedge clk);
    w0_req_valid = 1'b0;
    check("w0.rsp_valid", w0_rsp_valid, 1);
    check("w0.rsp_data", w0_rsp_data, 32'h00A0_0113);
    check("w0.rsp_err", w0_rsp_err, 0);
    check("w0.busy", w0_req_ready, 0);
    @(negedge clk);
    check("w0.ready_again", w0_req_ready, 1);
    check("w0.valid_drop", w0_rsp_valid, 0);
    w0_req_valid = 1'b1;
    w0_req_addr  = 32'h401;
    @(negedge clk);
    w0_req_valid = 1'b0;
    check("w0.fault_valid", w0_rsp_valid, 1);
    check("w0.fault_err", w0_rsp_err, 1);
    check("w0.fault_data", w0_rsp_data, 32'h0);
    @(negedge clk);
    w0_rsp_ready = 1'b0;
    check("w0.fault_ready_again", w0_req_ready, 1);

    // Asynchronous reset in the middle of WAIT
    w2_req_valid = 1'b1;
    w2_req_addr  = 32'hC;
    @(negedge clk);
    w2_req_valid = 1'b0;
    check("abort.in_wait_ready", w2_req_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("abort.rsp_valid", w2_rsp_valid, 0);
    check("abort.req_ready", w2_req_ready, 1);
    check("abort.rsp_data", w2_rsp_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    seen  = 0;
    repeat (5) begin
      @(negedge clk);
      if (w2_rsp_valid) seen++;
    end
    check("abort.no_response", seen, 0);
    w2_fetch("intact_c", 32'hC, 32'h2222_2222, 1'b0);
    w2_fetch("intact_0", 32'h0, 32'h0050_0093, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_imem_responder
`default_nettype wire

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, meaning data and address width.
REQ-002 The block SHALL expose parameter DEPTH, default 256, meaning the number of XLEN-bit words in the array.
REQ-003 The block SHALL expose parameter WAIT, default 2, range 0..7, meaning wait cycles inserted before each response.
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_addr  input  XLEN  byte address of the fetch (the core PC).
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  core accepts the response.
REQ-011 rsp_data  output  XLEN  fetched instruction word.
REQ-012 rsp_err  output  1  fetch fault (misaligned or out of range).
REQ-013 prog_we  input  1  program-load write strobe.
REQ-014 prog_addr  input  $clog2(DEPTH)  word index for the program load.
REQ-015 prog_data  input  XLEN  word to load.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; at most one request SHALL be outstanding.
REQ-018 On acceptance the word at index req_addr[2+:$clog2(DEPTH)] SHALL be captured into the response register, using the array content before any same-cycle program write.
REQ-019 The fault flag SHALL be captured at acceptance: rsp_err=1 when req_addr[1:0]!=0 or req_addr>>2 >= DEPTH, and rsp_data SHALL be 0 in that case.
REQ-020 With WAIT=0 the FSM SHALL go IDLE->RESP, making rsp_valid=1 exactly one cycle after acceptance.
REQ-021 With WAIT>0 the FSM SHALL go IDLE->WAIT, stay WAIT cycles, then enter RESP, making rsp_valid=1 exactly WAIT+1 cycles after acceptance.
REQ-022 In RESP, rsp_valid, rsp_data and rsp_err SHALL hold stable until rsp_ready=1; the FSM SHALL then go to IDLE on that edge.
REQ-023 rsp_ready SHALL be ignored outside RESP, and req_valid SHALL be ignored outside IDLE.
REQ-024 prog_we=1 SHALL write prog_data to prog_addr on the rising edge in any FSM state without disturbing a captured response.
REQ-025 The wait counter SHALL be $clog2(8) bits, SHALL load WAIT on entry to WAIT, and SHALL not wrap.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0 and wait counter=0, aborting any outstanding request.
REQ-027 Array contents SHALL NOT be cleared by reset, so a loaded program survives core resets.
REQ-028 After reset deasserts, the first request SHALL be acceptable on the first rising edge.

Structure
REQ-029 The state enum (IDLE, WAIT, RESP) and the fault-check width constants SHALL live in the shared package imem_pkg.
REQ-030 Storage SHALL be a sub-module imem_array, with synchronous write and a combinational read port, instantiated once.

Verification
REQ-031 WAIT=2: load 0x00500093 at index 0, request addr 0x0 -> rsp_valid 3 cycles after acceptance, rsp_data=0x00500093, rsp_err=0.
REQ-032 WAIT=0: request addr 0x4 holding 0x00A00113 with rsp_ready=1 -> rsp_valid 1 cycle later, and req_ready=1 again on the following cycle.
REQ-033 Request addr 0x6 -> rsp_err=1, rsp_data=0; request addr 4*DEPTH -> rsp_err=1.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_data stable for all 5 cycles, req_ready=0, and a req_valid pulse is ignored.
REQ-035 Accept addr 0x8, then write prog_data=0xFFFFFFFF to index 2 during WAIT -> response returns the old word, and a subsequent fetch of 0x8 returns 0xFFFFFFFF.
REQ-036 Assert reset=0 mid-WAIT -> rsp_valid=0 and req_ready=1 asynchronously, no response is issued, and array contents are intact.
